// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_pkg;

    // Default operand/result width; legal range 2..16.
    localparam int SUB_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/fullsubtractor_1bit.sv
// One-bit full subtractor computing a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no state, no handshake).
// Ports: a, b, bin in; diff = a^b^bin, bout = borrow out of this bit.
module fullsubtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign diff    = a_xor_b ^ bin;
    // A borrow leaves when b exceeds a, or when the bits are equal and a borrow came in.
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), bout = unsigned borrow, LSB first.
// Latency: out_valid rises WIDTH cycles after the accepting edge; one transaction at a time.
// Backpressure: valid/ready on both sides; result held stable while out_ready is low.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + a, b, bin operands,
//        out_valid/out_ready + diff, bout result; ovf present only with SUB_OVERFLOW_EN.
// Optional feature macro: SUB_OVERFLOW_EN (adds signed-overflow output ovf).
module serial_subtractor_4bit
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int IW = $clog2(WIDTH);

    sub_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic fs_diff;
    logic fs_bout;
    logic last_bit;

    // Operands are shifted right each RUN cycle so the single cell always sees bit 0.
    fullsubtractor_1bit u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign last_bit = (idx_q == IW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && ~rst) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                // Result bits enter at the MSB; after WIDTH shifts bit 0 lands at index 0.
                work_d   = {fs_diff, work_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                idx_d    = idx_q + IW'(1);
                if (last_bit) begin
                    // The visible result only changes here, so it keeps the previous value during RUN.
                    diff_d  = {fs_diff, work_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
`ifdef SUB_OVERFLOW_EN
                    // Signed overflow: borrow into the MSB differs from borrow out of it.
                    ovf_d   = borrow_q ^ fs_bout;
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit (WIDTH = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Define SUB_OVERFLOW_EN to also exercise the ovf output.
module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SUB_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    // Called at a falling edge; returns at the first falling edge after the accepting edge,
    // with the operand inputs scrambled so any late sampling shows up in the result.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
        int w;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        w        = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        bin      = ~tbin;
    endtask

    // Counts clock edges since acceptance until out_valid is seen; optionally wiggles out_ready
    // while the result is not yet valid.
    task automatic wait_result(input bit rand_rdy, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL result_timeout out_valid=%b required=1", out_valid);
        end
    endtask

    // Completes the output handshake and checks the block is ready again one cycle later.
    task automatic finish_hs(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_post_hs out_valid=%b in_ready=%b required out_valid=0 in_ready=1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic do_vec(input string nm, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic tbin, input logic [3:0] ediff, input logic ebout,
                          input logic eovf, input int elat);
        int lat;
        out_ready = 1'b1;
        send(ta, tb_v, tbin);
        wait_result(1'b0, lat);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=%0d", nm, lat, elat);
        end
        checks++;
        if (diff !== ediff || bout !== ebout) begin
            failures++;
            $display("FAIL %s_result diff=%h bout=%b required diff=%h bout=%b",
                     nm, diff, bout, ediff, ebout);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (ovf !== eovf) begin
            failures++;
            $display("FAIL %s_ovf got=%b required=%b", nm, ovf, eovf);
        end
`else
        if (eovf === 1'bx) $display("note: unexpected x in expectation for %s", nm);
`endif
        finish_hs(nm);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== 4'h0 || bout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state in_ready=%b out_valid=%b diff=%h bout=%b required 0 0 0 0",
                     in_ready, out_valid, diff, bout);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b required=0", ovf);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_directed;
        do_vec("sub_5_3",   4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, 4);
        do_vec("sub_3_5",   4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, 4);
        do_vec("sub_0_0_b", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4);
        do_vec("sub_0_F_b", 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0, 4);
        do_vec("sub_F_F",   4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4);
        do_vec("sub_F_0_b", 4'hF, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 4);
    endtask

    task automatic test_overflow;
        do_vec("ovf_8_1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 4);
        do_vec("ovf_7_1", 4'h7, 4'h1, 1'b0, 4'h6, 1'b0, 1'b0, 4);
        // 7 - (-1) = 8 overflows positively.
        do_vec("ovf_7_F", 4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 4);
    endtask

    task automatic test_stall;
        int         lat;
        logic [3:0] d0;
        logic       b0;
        bit         bad;
        out_ready = 1'b0;
        send(4'hC, 4'h4, 1'b1);
        wait_result(1'b0, lat);
        d0 = diff;
        b0 = bout;
        checks++;
        if (d0 !== 4'h7 || b0 !== 1'b0) begin
            failures++;
            $display("FAIL stall_result diff=%h bout=%b required diff=7 bout=0", d0, b0);
        end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d0 || bout !== b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_hold out_valid=%b in_ready=%b diff=%h bout=%b required 1 0 %h %b",
                     out_valid, in_ready, diff, bout, d0, b0);
        end
        finish_hs("stall");
    endtask

    task automatic test_reset_mid_run;
        bit bad;
        out_ready = 1'b1;
        send(4'h9, 4'h4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_in_reset in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'h0) begin
            failures++;
            $display("FAIL midrun_release in_ready=%b out_valid=%b diff=%h required 1 0 0",
                     in_ready, out_valid, diff);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midrun_no_result out_valid rose after abort, required stays 0");
        end
        do_vec("post_reset", 4'h6, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 4);
    endtask

    task automatic test_back_to_back;
        logic [3:0] ta, tb_v, ediff;
        logic       tbin, ebout, eovf;
        int         r, sa, sb, sr, stall, gap, lat;
        for (int n = 0; n < 200; n++) begin
            ta    = 4'($urandom_range(0, 15));
            tb_v  = 4'($urandom_range(0, 15));
            tbin  = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            gap   = $urandom_range(0, 2);
            r     = int'(ta) - int'(tb_v) - int'(tbin);
            ebout = (r < 0);
            ediff = 4'(r & 15);
            sa    = $signed(ta);
            sb    = $signed(tb_v);
            sr    = sa - sb - int'(tbin);
            eovf  = (sr < -8) || (sr > 7);
            out_ready = 1'($urandom_range(0, 1));
            send(ta, tb_v, tbin);
            wait_result(1'b1, lat);
            out_ready = (stall == 0);
            repeat (stall) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || diff !== ediff || bout !== ebout) begin
                failures++;
                $display("FAIL rand_%0d a=%h b=%h bin=%b got out_valid=%b diff=%h bout=%b required 1 %h %b",
                         n, ta, tb_v, tbin, out_valid, diff, bout, ediff, ebout);
            end
`ifdef SUB_OVERFLOW_EN
            checks++;
            if (ovf !== eovf) begin
                failures++;
                $display("FAIL rand_ovf_%0d a=%h b=%h bin=%b got=%b required=%b",
                         n, ta, tb_v, tbin, ovf, eovf);
            end
`endif
            out_ready = 1'b1;
            @(negedge clk);
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, bin are valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  diff/bout valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  borrow-out; 1 when a < b + bin, unsigned.
REQ-013 SHALL have port, only when SUB_OVERFLOW_EN is defined: ovf  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and never while rst = 1.
REQ-016 SHALL capture a, b, bin into internal registers and enter RUN with bit index 0 on an edge where in_valid && in_ready.
REQ-017 SHALL, in RUN, compute one difference bit per cycle, LSB first: diff[i] = a[i]^b[i]^borrow; borrow' = (~a[i]&b[i]) | (~(a[i]^b[i])&borrow); the borrow register starts at bin.
REQ-018 SHALL leave RUN after exactly WIDTH RUN cycles, writing bout = final borrow and setting out_valid = 1 in DONE.
REQ-019 SHALL raise out_valid exactly WIDTH cycles after the accepting edge.
REQ-020 SHALL hold diff, bout (and ovf) stable while out_valid = 1 && out_ready = 0, for any length of stall.
REQ-021 SHALL return to IDLE on an edge where out_valid && out_ready, clearing out_valid on that same edge.
REQ-022 SHALL NOT overlap transactions: a new acceptance can occur at the earliest one cycle after the result handshake.
REQ-023 SHALL ignore changes on a, b, bin after capture, and ignore out_ready outside DONE.
REQ-024 SHALL keep diff and bout holding the previous result in IDLE and RUN; they are meaningful only while out_valid = 1.

Reset
REQ-025 SHALL, when rst = 1 at a clock edge, set state = IDLE, out_valid = 0, diff = 0, bout = 0, ovf = 0, borrow = 0 and bit index = 0.
REQ-026 SHALL, on reset mid-RUN or mid-DONE, abort the transaction with no result produced; the first post-reset in_ready is in the cycle after rst falls.

Configuration
REQ-027 SHALL, with SUB_OVERFLOW_EN defined, add port ovf, set in DONE to (borrow into MSB) XOR (borrow out of MSB).
REQ-028 SHALL, without SUB_OVERFLOW_EN, have no ovf port, no ovf logic and otherwise identical behaviour.

Structure
REQ-029 SHALL take the FSM state typedef (IDLE/RUN/DONE) and the default width constant from the shared package sub_pkg.
REQ-030 SHALL compute each bit with one sub-module, fullsubtractor_1bit (inputs a, b, bin; outputs diff, bout; gate-level, purely combinational), instantiated once and time-multiplexed.

Verification
REQ-031 SHALL cover: a=5, b=3, bin=0 -> diff=2, bout=0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: a=3, b=5, bin=0 -> diff=4'hE, bout=1; and a=0, b=0, bin=1 -> diff=4'hF, bout=1.
REQ-033 SHALL cover, with SUB_OVERFLOW_EN: a=4'h8, b=1, bin=0 -> diff=4'h7, ovf=1; and a=4'h7, b=1 -> diff=6, ovf=0.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; after out_ready=1, in_ready=1 on the next cycle.
REQ-035 SHALL cover: rst asserted at RUN bit 2 -> out_valid never rises, in_ready=1 one cycle after rst falls, and the next transaction is correct.
REQ-036 SHALL cover: 200 random back-to-back transactions with random stalls -> every diff/bout matches (a - b - bin) mod 16 and its borrow.
